// File: rtl/txblock_pkg.sv
// rtl/txblock_pkg.sv - UART state encoding and line constants shared by transmitter and receiver
package txblock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   OVERSAMPLE_DEF = 16;
  localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/txblock_bit_timer.sv
// rtl/txblock_bit_timer.sv - per-bit oversample counter; bit_end marks the last cycle of a bit
module tx_bit_timer
  import txblock_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk16,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] sample_cnt;

  // Holding the counter at zero while idle restarts bit timing on every accept.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (!run || sample_cnt == LAST) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  assign bit_end = run && (sample_cnt == LAST);

endmodule

// File: rtl/txblock.sv
// rtl/txblock.sv - UART transmitter: start, LSB-first data, optional parity, stop bit(s)
module txblock
  import txblock_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk16,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] para_data_in,
  input  logic                 send_req,
  output logic                 serial_data_out,
  output logic                 tx_busy,
  output logic                 send_done
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity;
  logic [BW-1:0]        bit_cnt;
  logic                 bit_end;

  tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk16   (clk16),
    .rst_n   (rst_n),
    .run     (state != IDLE),
    .bit_end (bit_end)
  );

  // The line level for the next bit is registered on the edge that ends the current one.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shreg           <= '0;
      parity          <= 1'b0;
      bit_cnt         <= '0;
      serial_data_out <= LINE_IDLE;
      tx_busy         <= 1'b0;
      send_done       <= 1'b0;
    end else begin
      send_done <= 1'b0;
      case (state)
        IDLE: begin
          serial_data_out <= LINE_IDLE;
          if (send_req) begin
            shreg           <= para_data_in;
            parity          <= (^para_data_in) ^ (PARITY_ODD != 0);
            bit_cnt         <= '0;
            serial_data_out <= 1'b0;
            tx_busy         <= 1'b1;
            state           <= START;
          end
        end
        START: begin
          if (bit_end) begin
            serial_data_out <= shreg[0];
            state           <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                serial_data_out <= parity;
                state           <= PARITY;
              end else begin
                serial_data_out <= LINE_IDLE;
                state           <= STOP;
              end
            end else begin
              bit_cnt         <= bit_cnt + 1'b1;
              serial_data_out <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            serial_data_out <= LINE_IDLE;
            state           <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt   <= '0;
              tx_busy   <= 1'b0;
              send_done <= 1'b1;
              state     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/txblock.md
Name: txblock

Overview:
UART transmitter; the stage directly upstream of the UART receiver on the serial line. It accepts a parallel byte through a request handshake and shifts it out as one asynchronous serial frame. The frame is start bit, DATA_BITS data bits LSB first, optional parity, then stop bit(s). Each bit is held for OVERSAMPLE cycles of clk16, so that the receiver running on the same 16x clock samples it correctly.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8).
OVERSAMPLE, 16, clk16 cycles per serial bit.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk16  input  1  16x bit-rate clock, single clock domain, rising edge.
rst_n  input  1  asynchronous active-low reset.
para_data_in  input  DATA_BITS  byte to transmit; sampled only on the accepting edge.
send_req  input  1  transmit request, level-sampled.
serial_data_out  output  1  serial line, idle high, registered.
tx_busy  output  1  high while a frame is in flight.
send_done  output  1  one-cycle pulse when the last stop bit has completed.

Behaviour:
- Reset (asynchronous, immediate): serial_data_out=1, tx_busy=0, send_done=0, state=IDLE, all counters=0. Reset mid-frame aborts the frame; the line returns high at once and no send_done is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: line=1. If send_req=1 at a rising edge, latch para_data_in into the shift register and enter START at that edge. Registered effect at edge k+1: serial_data_out=0 and tx_busy=1.
- Every bit lasts exactly OVERSAMPLE cycles. sample_cnt runs 0..OVERSAMPLE-1; the bit ends at the edge where sample_cnt=OVERSAMPLE-1, and the counter wraps to 0.
- START -> DATA after one bit time.
- DATA: output shreg[0], shift right at each bit end. bit_cnt counts 0..DATA_BITS-1. After the last bit go to PARITY if PARITY_EN=1, else STOP.
- PARITY: output XOR of latched data, inverted when PARITY_ODD=1. Go to STOP after one bit time.
- STOP: line=1 for STOP_BITS bit times, then return to IDLE.
- On the edge that returns the block to IDLE: tx_busy=0, send_done=1 for exactly one cycle.
- Frame length (1+DATA_BITS+PARITY_EN+STOP_BITS)*OVERSAMPLE cycles; 160 cycles for 8N1.
- send_req while tx_busy=1 is ignored (no queuing, no error). para_data_in changes mid-frame have no effect.
- Back-to-back: send_req=1 during the send_done cycle is accepted at the next edge. The minimum inter-frame idle-high gap is 1 clk16 cycle beyond the stop bit(s).
- A held send_req retransmits the current para_data_in continuously with that 1-cycle gap.
- Counter widths: sample_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS+1) bits.

Decomposition:
- Shared uart package/include holds the state encoding (IDLE..STOP), the default OVERSAMPLE=16, and the idle line level. The same file is shared with the receiver.
- One natural sub-module: tx_bit_timer, which contains sample_cnt and generates a bit_end strobe. It is restartable from IDLE. The FSM, shift register and parity logic remain in txblock.

Test Plan:
- Reset then idle with send_req=0 for 500 cycles -> serial_data_out stays 1, tx_busy=0, send_done never pulses.
- para_data_in=0x59, 1-cycle send_req -> line pattern 0,1,0,0,1,1,0,1,0,1, each bit exactly 16 cycles. tx_busy high for 160 cycles, then one send_done pulse.
- Loopback of txblock into rxblock, send 0x59 then 0xA3 back-to-back (send_req held) -> rxblock para_data_out=0x59 then 0xA3, receive_flag asserted once per byte, 1-cycle idle gap between frames.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 176 cycles.
- send_req pulsed and para_data_in changed to 0xFF mid-frame of 0x00 -> frame still carries 0x00, no second frame, single send_done.
- rst_n asserted during data bit 4 -> serial_data_out=1 and tx_busy=0 immediately (asynchronous), no send_done. A new request after release transmits a correct full frame.
